// File: rtl/shift_add_datapath.sv
// shift_add_datapath
// Unsigned shift-and-add multiplier datapath driven by external strobes
// (clr, ld, ldp, shp, shb), with a protocol monitor FSM reporting busy,
// done and a sticky seq_err for illegal strobe orderings.
//
// Optional build macro: SHIFT_ADD_PRODUCT_HOLD_EN
//   defined   -> product is a register captured when the FSM enters DONE,
//                held until the next DONE, cleared by clr/reset.
//   undefined -> product is the live accumulator P.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | cleared/reset; only clr or ld legal, any op strobe -> seq_err
// LOAD  | operands loaded, waiting for the first op strobe
// RUN   | iterating; the shb that brings step to WIDTH ends the run
// DONE  | result frozen; shp/shb ignored, ldp -> seq_err

module shift_add_datapath #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               ld,
    input  logic               ldp,
    input  logic               shp,
    input  logic               shb,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [2*WIDTH-1:0] product,
    output logic               done,
    output logic               busy,
    output logic               seq_err
);

    localparam int SW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] p_q;
    logic               c_q;
    logic [SW-1:0]      step_q;

    logic               op;
    logic               add_en;
    logic               last_shb;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   cp_add;
    logic [2*WIDTH:0]   cp_nxt;

    // Next {C,P}: optional add into the upper half, then optional shift of that result
    always_comb begin
        op       = ldp | shp | shb;
        add_en   = ldp & b_q[0];
        last_shb = shb && (step_q == SW'(WIDTH - 1));
        sum      = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        cp_add   = add_en ? {sum, p_q[WIDTH-1:0]} : {c_q, p_q};
        cp_nxt   = shp ? {1'b0, cp_add[2*WIDTH:1]} : cp_add;
    end

    // Datapath registers and protocol monitor share one priority chain
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            c_q     <= 1'b0;
            step_q  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            seq_err <= 1'b0;
        end else if (clr) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            c_q     <= 1'b0;
            step_q  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            seq_err <= 1'b0;
        end else if (ld) begin
            state  <= LOAD;
            a_q    <= a_in;
            b_q    <= b_in;
            p_q    <= '0;
            c_q    <= 1'b0;
            step_q <= '0;
            done   <= 1'b0;
            busy   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (op) seq_err <= 1'b1;
                end
                LOAD, RUN: begin
                    if (op) begin
                        {c_q, p_q} <= cp_nxt;
                        if (shb) begin
                            b_q    <= b_q >> 1;
                            step_q <= step_q + SW'(1);
                        end
                        if (last_shb) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                DONE: begin
                    if (ldp) seq_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHIFT_ADD_PRODUCT_HOLD_EN
    logic [2*WIDTH-1:0] hold_q;
    logic               enter_done;

    assign enter_done = !clr && !ld && (state == LOAD || state == RUN) && last_shb;

    // Capture the final P (including any same-cycle add/shift) on entry to DONE
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            hold_q <= '0;
        end else if (enter_done) begin
            hold_q <= cp_nxt[2*WIDTH-1:0];
        end
    end

    assign product = hold_q;
`else
    assign product = p_q;
`endif

endmodule

// File: tb/tb_shift_add_datapath.sv
module tb_shift_add_datapath;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           clr = 1'b0, ld = 1'b0, ldp = 1'b0, shp = 1'b0, shb = 1'b0;
    logic [W-1:0]   a_in = '0, b_in = '0;
    logic [2*W-1:0] product;
    logic           done, busy, seq_err;

    int checks = 0;
    int errors = 0;

    shift_add_datapath #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .clr(clr), .ld(ld), .ldp(ldp), .shp(shp), .shb(shb),
        .a_in(a_in), .b_in(b_in), .product(product), .done(done), .busy(busy),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 loaded, 2 running, 3 finished
    int m_mode, m_a, m_b, m_p, m_c, m_step, m_err, m_hold;

    function automatic int exp_product();
`ifdef SHIFT_ADD_PRODUCT_HOLD_EN
        return m_hold;
`else
        return m_p;
`endif
    endfunction

    function automatic bit exp_done();
        return m_mode == 3;
    endfunction

    function automatic bit exp_busy();
        return m_mode == 1 || m_mode == 2;
    endfunction

    // Apply one cycle of strobes to DUT and model, sample #1 after the edge
    task automatic tick(input bit r, input bit c, input bit l, input bit lp,
                        input bit sp, input bit sb, input int a, input int b);
        int sum, full;
        reset = r; clr = c; ld = l; ldp = lp; shp = sp; shb = sb;
        a_in = W'(a); b_in = W'(b);
        if (!r) begin
            m_mode = 0; m_a = 0; m_b = 0; m_p = 0; m_c = 0; m_step = 0; m_err = 0; m_hold = 0;
        end else if (c) begin
            m_mode = 0; m_a = 0; m_b = 0; m_p = 0; m_c = 0; m_step = 0; m_err = 0; m_hold = 0;
        end else if (l) begin
            m_mode = 1; m_a = a & MASK; m_b = b & MASK; m_p = 0; m_c = 0; m_step = 0;
        end else if (m_mode == 0) begin
            if (lp || sp || sb) m_err = 1;
        end else if (m_mode == 3) begin
            if (lp) m_err = 1;
        end else if (lp || sp || sb) begin
            if (lp && (m_b % 2 == 1)) begin
                sum  = (m_p >> W) + m_a;
                m_p  = (m_p & MASK) + ((sum & MASK) << W);
                m_c  = sum >> W;
            end
            if (sp) begin
                full = m_c * (1 << (2 * W)) + m_p;
                full = full / 2;
                m_p  = full % (1 << (2 * W));
                m_c  = full / (1 << (2 * W));
            end
            if (sb) begin
                m_b    = m_b / 2;
                m_step = m_step + 1;
            end
            if (sb && m_step == W) begin
                m_mode = 3;
                m_hold = m_p;
            end else begin
                m_mode = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One multiply iteration in one of four strobe groupings
    task automatic iter(input int mode);
        case (mode)
            0: begin
                tick(1, 0, 0, 1, 0, 0, 0, 0);
                tick(1, 0, 0, 0, 1, 0, 0, 0);
                tick(1, 0, 0, 0, 0, 1, 0, 0);
            end
            1: begin
                tick(1, 0, 0, 1, 1, 0, 0, 0);
                tick(1, 0, 0, 0, 0, 1, 0, 0);
            end
            2: begin
                tick(1, 0, 0, 1, 0, 0, 0, 0);
                tick(1, 0, 0, 0, 1, 1, 0, 0);
            end
            default: tick(1, 0, 0, 1, 1, 1, 0, 0);
        endcase
    endtask

    task automatic idle_strobes();
        tick(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 1, 1, 1, 9, 9);
        checks += 4;
        if (product !== '0) begin errors++; $display("FAIL reset_product got %0d want 0", product); end
        if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err got %b want 0", seq_err); end
    endtask

    task automatic test_standard();
        tick(1, 1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0, 5, 3);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL std_busy_load got %b want 1", busy); end
        for (int i = 0; i < W; i++) begin
            tick(1, 0, 0, 1, 0, 0, 0, 0);
            tick(1, 0, 0, 0, 1, 0, 0, 0);
            checks++;
            if (product !== 8'(exp_product())) begin
                errors++; $display("FAIL std_product_iter%0d got %0d want %0d", i, product, exp_product());
            end
            tick(1, 0, 0, 0, 0, 1, 0, 0);
            checks++;
            if (done !== (i == W - 1)) begin
                errors++; $display("FAIL std_done_iter%0d got %b want %b", i, done, i == W - 1);
            end
        end
        checks += 3;
        if (product !== 8'd15) begin errors++; $display("FAIL std_product got %0d want 15", product); end
        if (busy !== 1'b0) begin errors++; $display("FAIL std_busy got %b want 0", busy); end
        if (seq_err !== 1'b0) begin errors++; $display("FAIL std_seq_err got %b want 0", seq_err); end
    endtask

    task automatic test_carry();
        tick(1, 0, 1, 0, 0, 0, 15, 15);
        for (int i = 0; i < W; i++) iter(1);
        checks += 2;
        if (product !== 8'd225) begin errors++; $display("FAIL carry_product got %0d want 225", product); end
        if (done !== 1'b1) begin errors++; $display("FAIL carry_done got %b want 1", done); end
    endtask

    task automatic test_zero();
        int ops [2][2] = '{'{0, 9}, '{9, 0}};
        for (int k = 0; k < 2; k++) begin
            tick(1, 0, 1, 0, 0, 0, ops[k][0], ops[k][1]);
            for (int i = 0; i < W; i++) iter(0);
            checks += 2;
            if (product !== '0) begin errors++; $display("FAIL zero_product%0d got %0d want 0", k, product); end
            if (done !== 1'b1) begin errors++; $display("FAIL zero_done%0d got %b want 1", k, done); end
        end
    endtask

    task automatic test_illegal();
        logic [2*W-1:0] held;
        tick(1, 1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 0, 0, 0, 0);
        checks += 2;
        if (seq_err !== 1'b1) begin errors++; $display("FAIL idle_ldp_seq_err got %b want 1", seq_err); end
        if (product !== '0) begin errors++; $display("FAIL idle_ldp_product got %0d want 0", product); end
        tick(1, 0, 1, 0, 0, 0, 3, 5);
        for (int i = 0; i < W; i++) iter(2);
        checks += 2;
        if (seq_err !== 1'b1) begin errors++; $display("FAIL sticky_seq_err got %b want 1", seq_err); end
        if (product !== 8'd15) begin errors++; $display("FAIL sticky_product got %0d want 15", product); end
        tick(1, 1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (seq_err !== 1'b0) begin errors++; $display("FAIL clr_seq_err got %b want 0", seq_err); end
        tick(1, 0, 1, 0, 0, 0, 7, 6);
        for (int i = 0; i < W; i++) iter(3);
        held = product;
        tick(1, 0, 0, 0, 1, 1, 0, 0);
        checks += 2;
        if (seq_err !== 1'b0) begin errors++; $display("FAIL done_shpshb_seq_err got %b want 0", seq_err); end
        if (product !== 8'd42) begin errors++; $display("FAIL done_shpshb_product got %0d want 42", product); end
        tick(1, 0, 0, 1, 0, 0, 0, 0);
        checks += 3;
        if (seq_err !== 1'b1) begin errors++; $display("FAIL done_ldp_seq_err got %b want 1", seq_err); end
        if (product !== held) begin errors++; $display("FAIL done_ldp_product got %0d want %0d", product, held); end
        if (done !== 1'b1) begin errors++; $display("FAIL done_ldp_done got %b want 1", done); end
        tick(1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_restart();
        tick(1, 0, 1, 0, 0, 0, 6, 7);
        iter(0);
        iter(0);
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        checks += 4;
        if (product !== '0) begin errors++; $display("FAIL midreset_product got %0d want 0", product); end
        if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        if (seq_err !== 1'b0) begin errors++; $display("FAIL midreset_seq_err got %b want 0", seq_err); end
        tick(1, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (seq_err !== 1'b1) begin errors++; $display("FAIL postreset_idle got %b want 1", seq_err); end
        tick(1, 1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0, 6, 7);
        iter(0);
        tick(1, 0, 1, 0, 0, 0, 6, 7);
        for (int i = 0; i < W; i++) iter(0);
        checks += 3;
        if (product !== 8'd42) begin errors++; $display("FAIL restart_product got %0d want 42", product); end
        if (seq_err !== 1'b0) begin errors++; $display("FAIL restart_seq_err got %b want 0", seq_err); end
        if (done !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", done); end
    endtask

    task automatic test_hold();
        tick(1, 0, 1, 0, 0, 0, 5, 3);
        for (int i = 0; i < W; i++) iter(0);
        tick(1, 0, 1, 0, 0, 0, 2, 2);
        for (int i = 0; i < W; i++) begin
            iter(0);
            checks++;
            if (product !== 8'(exp_product())) begin
                errors++; $display("FAIL hold_product_iter%0d got %0d want %0d", i, product, exp_product());
            end
        end
        checks++;
        if (product !== 8'd4) begin errors++; $display("FAIL hold_final got %0d want 4", product); end
    endtask

    task automatic test_random();
        int a, b;
        for (int n = 0; n < 24; n++) begin
            a = $urandom_range(MASK, 0);
            b = $urandom_range(MASK, 0);
            if ($urandom_range(3, 0) == 0) idle_strobes();
            tick(1, 0, 1, 0, 0, 0, a, b);
            for (int i = 0; i < W; i++) begin
                iter($urandom_range(3, 0));
                checks += 2;
                if (product !== 8'(exp_product())) begin
                    errors++; $display("FAIL rnd%0d_product got %0d want %0d", n, product, exp_product());
                end
                if (busy !== exp_busy() || done !== exp_done()) begin
                    errors++; $display("FAIL rnd%0d_status got busy=%b done=%b want busy=%b done=%b",
                                       n, busy, done, exp_busy(), exp_done());
                end
            end
            checks += 2;
            if (product !== 8'(a * b)) begin
                errors++; $display("FAIL rnd%0d_result %0d*%0d got %0d want %0d", n, a, b, product, a * b);
            end
            if (seq_err !== 1'b0) begin errors++; $display("FAIL rnd%0d_seq_err got %b want 0", n, seq_err); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_standard();
        test_carry();
        test_zero();
        test_illegal();
        test_reset_restart();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_add_datapath.md
Name: shift_add_datapath

Overview:
- Datapath end of the multiplier control interface: consumes the one-hot/combined strobes clr, ld, ldp, shp, shb from the sequencing controller and performs an unsigned shift-and-add multiply.
- Holds multiplicand A, multiplier shift register B, accumulator P with carry bit C, and a bit-step counter.
- A protocol monitor FSM tracks the strobe sequence, reports busy/done, and flags illegal strobe orderings on seq_err.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- clr  input  1  clear strobe.
- ld  input  1  load operands.
- ldp  input  1  conditional accumulate (add A to upper half of P if B[0]).
- shp  input  1  shift {C,P} right by 1.
- shb  input  1  shift B right by 1, advance step.
- a_in  input  WIDTH  multiplicand.
- b_in  input  WIDTH  multiplier.
- product  output  2*WIDTH  result.
- done  output  1  multiply complete.
- busy  output  1  operation in progress.
- seq_err  output  1  sticky illegal-sequence flag.

Behaviour:
- Reset: reset==0 at a clk edge clears A, B, P, C, step, done, busy, seq_err and product to 0; FSM goes to IDLE. Reset beats all strobes. Reset mid-operation abandons the operation with no residue.
- Priority each cycle: reset > clr > ld > {ldp, shp, shb}.
- clr clears A, B, P, C, step, done and seq_err; FSM goes to IDLE.
- ld: A<=a_in, B<=b_in, P<=0, C<=0, step<=0, done<=0; FSM goes to LOAD. ld is legal from any state; ld in RUN restarts without error. Any ldp, shp or shb in the same cycle is ignored.
- ldp: if B[0]==1, {C,P[2W-1:W]} <= P[2W-1:W] + A (W+1-bit sum). Otherwise P and C are unchanged.
- shp: {C,P} <= {1'b0, C, P[2W-1:1]}.
- shb: B <= B>>1; step <= step+1.
- Combined strobes in one cycle:
  - ldp with shp: add first, then shift the sum.
  - ldp with shb: ldp samples B[0] before the shift.
  - shp with shb: independent.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: only clr/ld are legal; ldp, shp or shb sets seq_err and leaves registers unchanged.
  - LOAD: the first ldp, shp or shb moves to RUN.
  - RUN: a shb that makes step==WIDTH moves to DONE.
  - DONE: registers frozen. shp and shb are ignored without error (controller idles with shp+shb). ldp sets seq_err and is ignored.
- busy = 1 in LOAD and RUN, registered with the state.
- done: registered; 1 in DONE, i.e. from the cycle after the WIDTH-th shb. Cleared by ld, clr or reset.
- seq_err: sticky; cleared only by clr or reset.
- step width: clog2(WIDTH+1) bits; it never wraps because shb is ignored in DONE.
- Arithmetic is unsigned throughout. After WIDTH iterations of (ldp, shp, shb), P == A*B exactly.
- product = P (live value).

Optional Feature:
- Macro: SHIFT_ADD_PRODUCT_HOLD_EN.
- Defined: product is a separate 2*WIDTH register.
  - Loaded with P on the cycle the FSM enters DONE.
  - Holds that value through later ld/RUN until the next DONE.
  - Cleared only by clr or reset.
- Undefined: product follows P combinationally every cycle, including intermediate values.

Test Plan:
- Standard sequence, WIDTH=4:
  - Stimulus: reset, clr, ld(a=5, b=3), then 4×(ldp; shp; shb) on separate cycles.
  - Response: product=15; done=1 one cycle after the 4th shb; busy=0; seq_err=0.
- Carry path:
  - Stimulus: a=15, b=15, same sequence, with ldp+shp in the same cycle each iteration.
  - Response: product=225, C=0 at end.
- Zero operand:
  - Stimulus: a=0, b=9, then a=9, b=0.
  - Response: product=0 both times; done asserted after the 4th shb.
- Illegal order:
  - Stimulus: ldp right after clr.
  - Response: seq_err=1 next cycle; P unchanged; seq_err stays 1 until clr.
  - Stimulus: ldp while in DONE.
  - Response: seq_err=1; product unchanged.
- Reset and restart:
  - Stimulus: reset=0 after the 2nd shb of a 6×7 run.
  - Response: all outputs 0, IDLE.
  - Stimulus: ld(6,7) mid-RUN, then a full sequence.
  - Response: product=42, seq_err=0.
- Hold macro:
  - With SHIFT_ADD_PRODUCT_HOLD_EN: 5×3 then ld(2,2) mid-run → product stays 15 until the second DONE shows 4.
  - Without it: product tracks P.
